// File: rtl/rib_arbiter.sv
// rib_arbiter: shares one bus slave port between core (m0), JTAG (m1), UART (m2).
// Fixed priority m1 > m2 > m0 with a core starvation guard and ack timeout.
module rib_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [DATA_W-1:0] m2_data_i,
    output logic [DATA_W-1:0] m2_data_o,
    output logic              m2_ack_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic              hold_flag_o,
    output logic              timeout_err_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [2:0]        ack_q, ack_d;
    logic              terr_q, terr_d;
    logic [DATA_W-1:0] rdata_q [3];
    logic [DATA_W-1:0] rdata_d [3];

    logic [1:0]        win;
    logic [2:0]        gnt_oh;
    logic              busy;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Core is forced through once it has lost STARVE_LIMIT arbitrations in a row.
    always_comb begin
        win = 2'd0;
        priority case (1'b1)
            m0_req_i && (starve_q == SLIM): win = 2'd0;
            m1_req_i:                       win = 2'd1;
            m2_req_i:                       win = 2'd2;
            default:                        win = 2'd0;
        endcase
    end

    always_comb begin
        sel_we   = m0_we_i;
        sel_addr = m0_addr_i;
        sel_data = m0_data_i;
        unique case (grant_q)
            2'd1: begin
                sel_we   = m1_we_i;
                sel_addr = m1_addr_i;
                sel_data = m1_data_i;
            end
            2'd2: begin
                sel_we   = m2_we_i;
                sel_addr = m2_addr_i;
                sel_data = m2_data_i;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q == BUSY);
    assign gnt_oh = {grant_q == 2'd2, grant_q == 2'd1, grant_q == 2'd0};

    assign s_req_o     = busy;
    assign s_we_o      = busy & sel_we;
    assign s_addr_o    = busy ? sel_addr : '0;
    assign s_data_o    = busy ? sel_data : '0;
    assign hold_flag_o = m1_req_i | m2_req_i
                       | ((state_q != IDLE) & (grant_q != 2'd0));

    assign m0_ack_o      = ack_q[0];
    assign m1_ack_o      = ack_q[1];
    assign m2_ack_o      = ack_q[2];
    assign m0_data_o     = rdata_q[0];
    assign m1_data_o     = rdata_q[1];
    assign m2_data_o     = rdata_q[2];
    assign timeout_err_o = terr_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        ack_d    = '0;
        terr_d   = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (m0_req_i && win != 2'd0) begin
                    starve_d = (starve_q == SLIM) ? SLIM : starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end
                if (m0_req_i | m1_req_i | m2_req_i) begin
                    grant_d = win;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ack_i) begin
                    ack_d   = gnt_oh;
                    tmo_d   = '0;
                    state_d = RESP;
                    for (int i = 0; i < 3; i++) begin
                        if (gnt_oh[i]) rdata_d[i] = s_data_i;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    ack_d   = gnt_oh;
                    terr_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = RESP;
                    for (int i = 0; i < 3; i++) begin
                        if (gnt_oh[i]) rdata_d[i] = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            starve_q <= '0;
            tmo_q    <= '0;
            ack_q    <= '0;
            terr_q   <= 1'b0;
            for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            ack_q    <= ack_d;
            terr_q   <= terr_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_rib_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int SL  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];
    logic [DW-1:0] s_din;
    logic          s_ack;

    logic [DW-1:0] rd0, rd1, rd2;
    logic          ack0, ack1, ack2;
    logic          s_req, s_we, hold, terr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_dout;
    logic [2:0]    ack;
    logic [DW-1:0] rd [3];

    assign ack   = {ack2, ack1, ack0};
    assign rd[0] = rd0;
    assign rd[1] = rd1;
    assign rd[2] = rd2;

    rib_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
        .m0_data_i(wdata[0]), .m0_data_o(rd0), .m0_ack_o(ack0),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
        .m1_data_i(wdata[1]), .m1_data_o(rd1), .m1_ack_o(ack1),
        .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]),
        .m2_data_i(wdata[2]), .m2_data_o(rd2), .m2_ack_o(ack2),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_data_o(s_dout), .s_data_i(s_din), .s_ack_i(s_ack),
        .hold_flag_o(hold), .timeout_err_o(terr)
    );

    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    endtask

    // Model: phase 0 idle, 1 slave access in flight, 2 response cycle.
    int            ph, own, lost, bcnt;
    logic [2:0]    e_ack;
    logic [DW-1:0] e_rd [3];
    logic          e_terr;

    task automatic model_reset();
        ph = 0; own = 0; lost = 0; bcnt = 0;
        e_ack = '0; e_terr = 1'b0;
        for (int i = 0; i < 3; i++) e_rd[i] = '0;
    endtask

    task automatic model_compare();
        logic          bz;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        bz = (ph == 1);
        ea = bz ? addr[own]  : '0;
        ed = bz ? wdata[own] : '0;
        ew = bz ? we[own]    : 1'b0;
        chk("s_req", s_req, bz);
        chk("s_we", s_we, ew);
        chk("s_addr", s_addr, ea);
        chk("s_data", s_dout, ed);
        chk("hold", hold, req[1] | req[2] | (ph != 0 && own != 0));
        chk("ack", ack, e_ack);
        chk("terr", terr, e_terr);
        for (int i = 0; i < 3; i++) chk($sformatf("rdata%0d", i), rd[i], e_rd[i]);
    endtask

    task automatic model_step();
        logic [2:0] n_ack;
        logic       n_terr;
        int         w;
        n_ack = '0;
        n_terr = 1'b0;
        case (ph)
            0: begin
                if (|req) begin
                    if (req[0] && lost == SL) w = 0;
                    else if (req[1]) w = 1;
                    else if (req[2]) w = 2;
                    else w = 0;
                    if (req[0] && w != 0) lost = (lost < SL) ? lost + 1 : SL;
                    else lost = 0;
                    own = w; ph = 1; bcnt = 0;
                end else begin
                    lost = 0;
                end
            end
            1: begin
                bcnt++;
                if (s_ack) begin
                    n_ack[own] = 1'b1; e_rd[own] = s_din; ph = 2;
                end else if (bcnt == TMO) begin
                    n_ack[own] = 1'b1; e_rd[own] = '0; n_terr = 1'b1; ph = 2;
                end
            end
            default: ph = 0;
        endcase
        e_ack = n_ack;
        e_terr = n_terr;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cyc();
        #1;
        model_compare();
        model_step();
        @(negedge clk);
    endtask

    int ord [$];
    int cnt;
    logic [2:0] done;
    logic [2:0] pend;
    logic d2;
    int mode;

    initial begin
        rst = 1'b0;
        req = '0; we = '0; s_ack = 1'b0; s_din = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_s_req", s_req, 0);
        chk("rst_ack", ack, 0);
        chk("rst_hold", hold, 0);
        chk("rst_rd0", rd0, 0);
        rst = 1'b1;
        cyc();

        // m0 read with single-cycle slave ack
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h1000_0004;
        #1;
        chk("t1_hold0", hold, 0);
        cyc();
        s_ack = 1'b1; s_din = 32'hA5A5_0001;
        #1;
        chk("t1_sreq", s_req, 1);
        chk("t1_saddr", s_addr, 32'h1000_0004);
        chk("t1_hold1", hold, 0);
        cyc();
        req[0] = 1'b0; s_ack = 1'b0;
        #1;
        chk("t1_ack", ack, 3'b001);
        chk("t1_rd", rd0, 32'hA5A5_0001);
        chk("t1_hold2", hold, 0);
        cyc();
        chk("t1_ack_end", ack, 0);
        cyc();

        // all three request together
        for (int i = 0; i < 3; i++) begin
            addr[i] = 32'h100 * (i + 1); we[i] = 1'b0;
        end
        req = 3'b111; done = '0; s_ack = 1'b1; ord.delete();
        for (int c = 0; c < 11; c++) begin
            d2 = done[2];
            for (int i = 0; i < 3; i++) if (ack[i]) begin req[i] = 1'b0; done[i] = 1'b1; end
            s_din = $urandom;
            #1;
            if (!d2) chk("t2_hold", hold, 1);
            if (s_req) begin
                ord.push_back(int'(s_addr >> 8) - 1);
                if (s_addr == 32'h100) chk("t2_hold_m0", hold, 0);
            end
            cyc();
        end
        chk("t2_nord", ord.size(), 3);
        if (ord.size() == 3) begin
            chk("t2_ord0", ord[0], 1);
            chk("t2_ord1", ord[1], 2);
            chk("t2_ord2", ord[2], 0);
        end

        // m0 and m1 both request continuously: m0 forced in on the 5th
        ord.delete();
        for (int c = 0; c < 18; c++) begin
            req[0] = !ack[0];
            req[1] = !ack[1];
            s_din = $urandom;
            #1;
            if (s_req) ord.push_back(int'(s_addr >> 8) - 1);
            cyc();
        end
        req = '0;
        cyc();
        chk("t3_nord", ord.size(), 6);
        if (ord.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("t3_win%0d", k), ord[k], (k == 4) ? 0 : 1);
        end

        // m2 write, slave never acks
        s_ack = 1'b0;
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h2000_0000; wdata[2] = 32'hDEAD_BEEF;
        cyc();
        #1;
        chk("t4_swe", s_we, 1);
        chk("t4_sdata", s_dout, 32'hDEAD_BEEF);
        cnt = 0;
        for (int k = 0; k < 40 && !ack2; k++) begin
            if (s_req) cnt++;
            cyc();
        end
        #1;
        chk("t4_busy_len", cnt, 16);
        chk("t4_ack", ack, 3'b100);
        chk("t4_rd", rd2, 0);
        chk("t4_terr", terr, 1);
        req[2] = 1'b0;
        cyc();
        #1;
        chk("t4_idle_sreq", s_req, 0);
        chk("t4_idle_terr", terr, 0);
        cyc();

        // m0 drops req while its access is in flight
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30;
        cyc();
        req[0] = 1'b0;
        cyc();
        s_ack = 1'b1; s_din = 32'h5555_AAAA;
        cyc();
        s_ack = 1'b0;
        #1;
        chk("t5_ack", ack, 3'b001);
        chk("t5_rd", rd0, 32'h5555_AAAA);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (ack0) cnt++;
        end
        chk("t5_no_extra_ack", cnt, 0);

        // reset while m1 owns the bus
        req[1] = 1'b1; addr[1] = 32'h44;
        cyc();
        #1;
        chk("t6_busy", s_req, 1);
        req[1] = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("t6_sreq", s_req, 0);
        chk("t6_ack", ack, 0);
        chk("t6_hold", hold, 0);
        chk("t6_saddr", s_addr, 0);
        chk("t6_rd0", rd0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (|ack) cnt++;
        end
        chk("t6_no_stale_ack", cnt, 0);

        // randomized traffic
        pend = '0; req = '0; mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 256 == 0) mode = $urandom_range(1);
            for (int i = 0; i < 3; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0; pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1; pend[i] = 1'b1;
                    we[i] = 1'($urandom_range(1));
                    addr[i] = $urandom; wdata[i] = $urandom;
                end else if (req[i] && ph == 1 && own == i && $urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
                if (pend[i] && $urandom_range(7) == 0) wdata[i] = $urandom;
            end
            s_ack = (mode == 1) ? ($urandom_range(19) == 0) : 1'($urandom_range(1));
            s_din = $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
